// File: rtl/mpmc12_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : mpmc12_burst_addr_gen
// Description : Burst address generator for the multi-port memory controller
//               datapath. Latches a burst descriptor and steps a beat-aligned
//               address once per accepted beat (INCR, WRAP, FIXED).
// Revision    : 1.0 - initial release
// ============================================================================
module mpmc12_burst_addr_gen #(
    parameter int WID  = 256,
    parameter int AWID = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [5:0]      burst_len,
    input  logic [1:0]      burst_type,
    input  logic [AWID-1:0] addr_base,
    input  logic            rdy,
    input  logic            abort,
    output logic [AWID-1:0] addr,
    output logic            addr_vld,
    output logic            last,
    output logic            busy,
    output logic            done
);

    // Bytes per beat and the number of address bits that address within a beat
    localparam int c_INC_AMT = WID / 8;
    localparam int c_LSB     = $clog2(c_INC_AMT);

    localparam logic [AWID-1:0] c_INC      = AWID'(c_INC_AMT);
    localparam logic [AWID-1:0] c_LSB_MASK = AWID'(c_INC_AMT - 1);

    // Controller states
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Resolved addressing mode for the burst in flight
    localparam logic [1:0] c_MODE_INCR  = 2'd0;
    localparam logic [1:0] c_MODE_WRAP  = 2'd1;
    localparam logic [1:0] c_MODE_FIXED = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;

    logic [AWID-1:0] r_addr;
    logic [5:0]      r_beat_cnt;
    logic [5:0]      r_len_q;
    logic [1:0]      r_mode;
    logic [AWID-1:0] r_mask;

    logic [6:0]      w_len_p1;
    logic            w_wrap_ok;
    logic [AWID-1:0] w_mask;
    logic [1:0]      w_mode;
    logic [AWID-1:0] w_base_aligned;
    logic [AWID-1:0] w_addr_inc;
    logic [AWID-1:0] w_addr_next;
    logic            w_last;

    // Descriptor decode: wrap is only honoured for power-of-two beat counts up
    // to 32; anything else falls back to incrementing, fixed for the burst.
    always_comb begin
        w_len_p1       = {1'b0, burst_len} + 7'd1;
        w_wrap_ok      = ((w_len_p1 & (w_len_p1 - 7'd1)) == 7'd0) && (w_len_p1 <= 7'd32);
        w_mask         = (AWID'(w_len_p1) << c_LSB) - AWID'(1);
        w_base_aligned = addr_base & ~c_LSB_MASK;
        case (burst_type)
            2'd1:    w_mode = w_wrap_ok ? c_MODE_WRAP : c_MODE_INCR;
            2'd2:    w_mode = c_MODE_FIXED;
            default: w_mode = c_MODE_INCR;
        endcase
    end

    // Next beat address; carry out of the MSB is dropped by the AWID-bit add
    always_comb begin
        w_addr_inc = r_addr + c_INC;
        case (r_mode)
            c_MODE_FIXED: w_addr_next = r_addr;
            c_MODE_WRAP:  w_addr_next = (r_addr & ~r_mask) | (w_addr_inc & r_mask);
            default:      w_addr_next = w_addr_inc;
        endcase
    end

    // Final-beat flag comes only from registered count/length
    assign w_last = (r_state == c_ST_RUN) && (r_beat_cnt == r_len_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort beats rdy, start is only looked at in IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (abort) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (rdy && w_last) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Descriptor capture and per-beat address/count stepping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_beat_cnt <= '0;
            r_len_q    <= '0;
            r_mode     <= c_MODE_INCR;
            r_mask     <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_addr     <= w_base_aligned;
                        r_beat_cnt <= '0;
                        r_len_q    <= burst_len;
                        r_mode     <= w_mode;
                        r_mask     <= w_mask;
                    end
                end
                c_ST_RUN: begin
                    if (!abort && rdy && !w_last) begin
                        r_beat_cnt <= r_beat_cnt + 6'd1;
                        r_addr     <= w_addr_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode from registered state; address forced to zero when idle
    always_comb begin
        addr     = '0;
        addr_vld = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        last     = w_last;
        case (r_state)
            c_ST_RUN: begin
                addr     = r_addr;
                addr_vld = 1'b1;
                busy     = 1'b1;
            end
            c_ST_DONE: begin
                addr     = r_addr;
                busy     = 1'b1;
                done     = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mpmc12_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_mpmc12_burst_addr_gen
// Description : Self-checking bench for mpmc12_burst_addr_gen. A behavioural
//               model precomputes each burst's address list arithmetically
//               and every output is compared on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mpmc12_burst_addr_gen;

    localparam int  WID  = 256;
    localparam int  AWID = 32;
    localparam longint INC = WID / 8;

    logic            clk;
    logic            rst;
    logic            start;
    logic [5:0]      burst_len;
    logic [1:0]      burst_type;
    logic [AWID-1:0] addr_base;
    logic            rdy;
    logic            abort;
    logic [AWID-1:0] addr;
    logic            addr_vld;
    logic            last;
    logic            busy;
    logic            done;

    mpmc12_burst_addr_gen #(.WID(WID), .AWID(AWID)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .burst_len  (burst_len),
        .burst_type (burst_type),
        .addr_base  (addr_base),
        .rdy        (rdy),
        .abort      (abort),
        .addr       (addr),
        .addr_vld   (addr_vld),
        .last       (last),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: phase 0 idle, 1 issuing beats, 2 completion pulse
    int              m_phase = 0;
    int              m_idx   = 0;
    int              m_len   = 0;
    logic [31:0]     m_q[$];
    logic [31:0]     obs_q[$];
    logic [31:0]     exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Whole-burst address list straight from the burst rules
    function automatic void build(input logic [31:0] base, input int len, input int typ);
        longint b;
        longint span;
        longint wb;
        longint a;
        bit     wrap_ok;
        b       = longint'(base) - (longint'(base) % INC);
        span    = longint'(len + 1) * INC;
        wrap_ok = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            if (len + 1 == (1 << k)) wrap_ok = 1'b1;
        end
        m_q.delete();
        for (int i = 0; i <= len; i++) begin
            if (typ == 2) begin
                a = b;
            end else if (typ == 1 && wrap_ok) begin
                wb = b - (b % span);
                a  = wb + ((b - wb + longint'(i) * INC) % span);
            end else begin
                a = (b + longint'(i) * INC) % 64'h1_0000_0000;
            end
            m_q.push_back(a[31:0]);
        end
    endfunction

    // One clock: compare outputs, apply inputs, advance the model at the edge
    task automatic cyc(input logic s, input logic [5:0] l, input logic [1:0] t,
                       input logic [31:0] b, input logic r, input logic a, input logic rs);
        logic [31:0] e_addr;
        logic        e_vld, e_last, e_busy, e_done;
        e_addr = '0; e_vld = 1'b0; e_last = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        if (m_phase == 1) begin
            e_addr = m_q[m_idx]; e_vld = 1'b1; e_last = (m_idx == m_len); e_busy = 1'b1;
        end else if (m_phase == 2) begin
            e_addr = m_q[m_len]; e_busy = 1'b1; e_done = 1'b1;
        end
        check("addr",     64'(addr),     64'(e_addr));
        check("addr_vld", 64'(addr_vld), 64'(e_vld));
        check("last",     64'(last),     64'(e_last));
        check("busy",     64'(busy),     64'(e_busy));
        check("done",     64'(done),     64'(e_done));
        if (addr_vld && r && !a && !rs) obs_q.push_back(addr);
        start = s; burst_len = l; burst_type = t; addr_base = b;
        rdy = r; abort = a; rst = rs;
        @(posedge clk);
        if (rs) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (s) begin
                    build(b, int'(l), int'(t));
                    m_idx = 0; m_len = int'(l); m_phase = 1;
                end
                1: if (a) begin
                    m_phase = 0;
                end else if (r) begin
                    if (m_idx == m_len) m_phase = 2;
                    else m_idx++;
                end
                default: m_phase = 0;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 6'd0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic finish_burst();
        int n;
        for (n = 0; n < 200 && m_phase != 0; n++) cyc(1'b0, 6'd0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        if (m_phase != 0) check("timeout", 64'(m_phase), 64'd0);
    endtask

    task automatic burst_all_rdy(input logic [5:0] l, input logic [1:0] t, input logic [31:0] b);
        obs_q.delete();
        cyc(1'b1, l, t, b, 1'b1, 1'b0, 1'b0);
        finish_burst();
        idle(1);
    endtask

    task automatic check_obs(input string tag);
        check({tag, "_len"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check(tag, 64'(obs_q[i]), 64'(exp_q[i]));
    endtask

    initial begin
        start = 1'b0; burst_len = '0; burst_type = '0; addr_base = '0;
        rdy = 1'b0; abort = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_phase = 0;
        cyc(1'b0, 6'd0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Incrementing from an unaligned base
        burst_all_rdy(6'd3, 2'd0, 32'h1000_0013);
        exp_q = '{32'h1000_0000, 32'h1000_0020, 32'h1000_0040, 32'h1000_0060};
        check_obs("incr_seq");

        // Wrapping over a 128-byte span
        burst_all_rdy(6'd3, 2'd1, 32'h0000_0140);
        exp_q = '{32'h140, 32'h160, 32'h100, 32'h120};
        check_obs("wrap_seq");

        // Wrap with a three-beat burst degrades to incrementing
        burst_all_rdy(6'd2, 2'd1, 32'h0000_0140);
        exp_q = '{32'h140, 32'h160, 32'h180};
        check_obs("wrap3_seq");

        // Fixed address
        burst_all_rdy(6'd2, 2'd2, 32'h0000_0080);
        exp_q = '{32'h80, 32'h80, 32'h80};
        check_obs("fixed_seq");

        // Stall pattern with an ignored start mid-burst
        obs_q.delete();
        cyc(1'b1, 6'd1, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 6'd0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 6'd5, 2'd2, 32'h8000, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 6'd0, 2'd0, 32'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 6'd0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 6'd0, 2'd0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("stall_done", 64'(done), 64'd1);
        idle(2);
        exp_q = '{32'h0, 32'h20};
        check_obs("stall_seq");

        // Abort with rdy on beat 2, then start+abort together in IDLE
        cyc(1'b1, 6'd7, 2'd0, 32'h2000, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 6'd0, 2'd0, 32'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 6'd0, 2'd0, 32'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 6'd0, 2'd0, 32'h0, 1'b1, 1'b1, 1'b0);
        check("abort_idle", 64'({addr_vld, busy, done}), 64'd0);
        cyc(1'b1, 6'd0, 2'd2, 32'h3000, 1'b1, 1'b1, 1'b0);
        check("abort_restart", 64'(addr), 64'h3000);
        finish_burst();
        idle(1);

        // Reset mid-burst
        cyc(1'b1, 6'd5, 2'd1, 32'h4000, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 6'd0, 2'd0, 32'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 6'd0, 2'd0, 32'h0, 1'b1, 1'b0, 1'b1);
        check("rst_mid", 64'({addr, addr_vld, busy, done, last}), 64'd0);
        idle(1);

        // Address wrap-around at the top of the space
        burst_all_rdy(6'd1, 2'd0, 32'hFFFF_FFE0);
        exp_q = '{32'hFFFF_FFE0, 32'h0000_0000};
        check_obs("top_wrap_seq");

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] l;
            if ($urandom_range(0, 1) == 0) l = 6'((1 << $urandom_range(0, 5)) - 1);
            else                           l = 6'($urandom_range(0, 63));
            cyc(($urandom_range(0, 3) == 0), l, 2'($urandom_range(0, 3)), $urandom,
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0),
                ($urandom_range(0, 299) == 0));
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mpmc12_burst_addr_gen.md
# mpmc12_burst_addr_gen

Parametrised burst address generator for the multi-port memory controller datapath. It accepts a burst descriptor (base address, beat count, burst type), then steps a beat-aligned address once per accepted beat, supporting incrementing, wrapping and fixed bursts at any power-of-two data width. It sits between the port arbiter/state sequencer and the memory interface command/data path, replacing the fixed-width incrementing-only generator.

## Interface
- WID, 256, data beat width in bits; power of two, 64..1024; INC_AMT = WID/8 bytes, LSB = log2(INC_AMT)
- AWID, 32, address width in bits
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  descriptor valid; sampled only in IDLE
- burst_len  in  6  beats minus one (0..63); sampled with start
- burst_type  in  2  0=INCR, 1=WRAP, 2=FIXED, 3=reserved (treated as INCR); sampled with start
- addr_base  in  AWID  byte start address; sampled with start
- rdy  in  1  memory side accepted current beat/address this cycle
- abort  in  1  terminate current burst, no done pulse
- addr  out  AWID  current beat address, low LSB bits always 0
- addr_vld  out  1  addr is valid for the current beat
- last  out  1  current beat is the final beat of the burst
- busy  out  1  generator not in IDLE
- done  out  1  one-cycle pulse after final beat accepted

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: addr=0, addr_vld=0, last=0, done=0, busy=0. start=1 → latch len, type, aligned base ({addr_base[AWID-1:LSB], LSB'b0}); → RUN; beat_cnt=0.
- RUN: addr_vld=1, busy=1; last = (beat_cnt==len_q). On rdy: if last → DONE; else beat_cnt+1 and addr advances per type. rdy=0 → addr, beat_cnt held.
- DONE: done=1, addr_vld=0, busy=1, addr held; unconditional → IDLE next cycle.
- Advance rules (AWID-bit modulo arithmetic, carry out of MSB discarded):
  - INCR: addr + INC_AMT.
  - FIXED: addr unchanged.
  - WRAP: span = (len_q+1)*INC_AMT, mask = span-1; addr_next = (addr & ~mask) | ((addr + INC_AMT) & mask). Valid only for len_q+1 ∈ {1,2,4,8,16,32}; any other length (including 64) behaves as INCR for that burst, decided at start.
- len_q=0: single beat, last=1 on first RUN cycle; addr never advances, for all types.
- start while busy: ignored, not queued.
- abort: any state except IDLE → IDLE next edge; done not pulsed; outputs take IDLE values. abort has priority over rdy in the same cycle. abort in IDLE ignored; abort and start together in IDLE: start wins.
- rst mid-burst: all outputs to reset values next edge; descriptor discarded.

## Timing
- Reset values: addr=0, addr_vld=0, last=0, busy=0, done=0.
- start sampled at edge N → addr_vld=1 with base address from edge N (visible cycle N+1). busy rises same edge.
- All outputs registered except last, which is combinational from registered beat_cnt/len_q (no input-to-output path).
- Each rdy-high RUN cycle consumes exactly one beat; minimum burst of L+1 beats takes L+1 RUN cycles + 1 DONE cycle.
- Back-to-back: earliest next start accepted in the IDLE cycle following DONE (2-cycle gap after final beat).

## Test plan
- WID=256, INCR, addr_base=0x1000_0013, len=3, rdy=1 → addr 0x1000_0000, 0x1000_0020, 0x1000_0040, 0x1000_0060; last only on 4th; done one cycle later; busy low after.
- WRAP, addr_base=0x0000_0140, len=3 (span 128 B) → 0x140, 0x160, 0x100, 0x120; then DONE.
- WRAP, len=2 (non-power-of-two) from 0x140 → 0x140, 0x160, 0x180 (INCR behaviour); FIXED, len=2 base 0x80 → 0x80 ×3.
- Stall: INCR len=1 base 0, rdy pattern 0,0,1,0,1 → addr held 0 for 3 cycles, 0x20 for 2, done after 5th cycle; start pulsed mid-burst ignored.
- abort asserted with rdy on beat 2 of len=7 → IDLE next edge, addr=0, no done; new start next cycle accepted normally. rst mid-burst → all outputs 0 next edge.
- INCR wrap-around: base 0xFFFF_FFE0, len=1 → 0xFFFF_FFE0, 0x0000_0000.
